// File: rtl/add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // One extra bit beyond clog2 so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module full_add_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p, g1, g2;

    assign p  = x ^ y;
    assign g1 = x & y;
    assign s  = p ^ cin;
    assign g2 = p & cin;
    assign co = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder behind a start/done handshake: one full-adder cell,
// one carry flop, operands consumed LSB-first one bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | adding bit cnt_q; busy high
//   DONE  | result valid, done pulse; start accepted here as in IDLE
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-2:0] res_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             sum_bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    full_add_cell u_fa (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .cin (carry_q),
        .s   (sum_bit_d),
        .co  (carry_d)
    );

    // The register keeps only the WIDTH-1 settled bits; the live sum bit
    // completes the word, so on the last RUN edge res_d is the full result.
    assign res_d = {sum_bit_d, res_sr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        res_sr_q <= '0;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    res_sr_q <= res_d[WIDTH-1:1];
                    carry_q  <= carry_d;
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum     <= res_d;
                        cout    <= carry_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) plus the full_add_cell truth table.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    logic fx, fy, fc, fs, fco;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cyc1, done_cyc2;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    full_add_cell u_cell (
        .x   (fx),
        .y   (fy),
        .cin (fc),
        .s   (fs),
        .co  (fco)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Golden result from plain integer addition.
    task automatic model_add(input logic [W-1:0] ai, input logic [W-1:0] bi);
        int total;
        total    = int'(ai) + int'(bi);
        exp_sum  = W'(total % (1 << W));
        exp_cout = (total >= (1 << W));
    endtask

    // Issues one operation; optionally pulses start with other operands
    // during RUN cycle glitch_cyc, which must be ignored.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input int glitch_cyc, input logic [W-1:0] ga,
                          input logic [W-1:0] gb);
        start = 1'b1; a = ai; b = bi;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int c = 0; c < W; c++) begin
            chk("run_busy", 32'(busy), 32'(1'b1));
            chk("run_done", 32'(done), 32'(1'b0));
            chk("run_hold_sum", 32'(sum), 32'(exp_sum));
            chk("run_hold_cout", 32'(cout), 32'(exp_cout));
            if (c == glitch_cyc) begin
                start = 1'b1; a = ga; b = gb;
            end
            tick();
            start = 1'b0; a = W'($urandom); b = W'($urandom);
        end
        model_add(ai, bi);
        chk("done_pulse", 32'(done), 32'(1'b1));
        chk("done_busy", 32'(busy), 32'(1'b0));
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("cout", 32'(cout), 32'(exp_cout));
        tick();
        chk("done_clear", 32'(done), 32'(1'b0));
        chk("idle_busy", 32'(busy), 32'(1'b0));
        chk("idle_sum", 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        fx = 1'b0; fy = 1'b0; fc = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;

        // reset for two cycles
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        tick();
        chk("idle_nostart", 32'(busy), 32'h0);

        // directed operations
        run_op(8'd3, 8'd5, -1, '0, '0);
        chk("t1_sum", 32'(sum), 32'd8);
        run_op(8'd255, 8'd1, -1, '0, '0);
        chk("t2a_cout", 32'(cout), 32'd1);
        run_op(8'd200, 8'd100, -1, '0, '0);
        chk("t2b_sum", 32'(sum), 32'd44);
        run_op(8'd0, 8'd0, -1, '0, '0);

        // full-adder cell exhaustive truth table
        for (int r = 0; r < 8; r++) begin
            int ones;
            fx = r[0]; fy = r[1]; fc = r[2];
            #1;
            ones = int'(fx) + int'(fy) + int'(fc);
            chk("cell_s", 32'(fs), 32'(ones % 2));
            chk("cell_co", 32'(fco), 32'(ones / 2));
        end

        // start while busy is ignored
        run_op(8'd10, 8'd20, 3, 8'd1, 8'd1);
        chk("t4_sum", 32'(sum), 32'd30);

        // reset in the middle of RUN aborts with no done pulse
        start = 1'b1; a = 8'd100; b = 8'd27;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("abort_run_busy", 32'(busy), 32'(1'b1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            chk("abort_sum", 32'(sum), 32'h0);
            chk("abort_cout", 32'(cout), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_done", 32'(done), 32'h0);
            tick();
        end
        run_op(8'd7, 8'd9, -1, '0, '0);
        chk("t5_sum", 32'(sum), 32'd16);

        // back-to-back with start held high
        start = 1'b1; a = 8'd15; b = 8'd17;
        tick();
        for (int c = 0; c < W; c++) begin
            chk("b2b1_busy", 32'(busy), 32'(1'b1));
            chk("b2b1_done", 32'(done), 32'(1'b0));
            tick();
        end
        done_cyc1 = cyc;
        chk("b2b1_done_pulse", 32'(done), 32'(1'b1));
        chk("b2b1_sum", 32'(sum), 32'd32);
        chk("b2b1_cout", 32'(cout), 32'd0);
        a = 8'd128; b = 8'd128;
        tick();
        a = W'($urandom); b = W'($urandom);
        for (int c = 0; c < W; c++) begin
            chk("b2b2_busy", 32'(busy), 32'(1'b1));
            chk("b2b2_done", 32'(done), 32'(1'b0));
            chk("b2b2_hold", 32'(sum), 32'd32);
            if (c == W - 1) start = 1'b0;
            tick();
        end
        done_cyc2 = cyc;
        chk("b2b2_done_pulse", 32'(done), 32'(1'b1));
        chk("b2b2_sum", 32'(sum), 32'd0);
        chk("b2b2_cout", 32'(cout), 32'd1);
        chk("b2b_spacing", 32'(done_cyc2 - done_cyc1), 32'd9);
        exp_sum = '0; exp_cout = 1'b1;
        tick();
        chk("b2b_idle", 32'(busy), 32'h0);
        chk("b2b_done_clear", 32'(done), 32'h0);

        // randomized operations against the integer model
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb, ga, gb;
            int gc;
            ra = W'($urandom);
            rb = W'($urandom);
            ga = W'($urandom);
            gb = W'($urandom);
            gc = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, W - 1));
            run_op(ra, rb, gc, ga, gb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder: the addition counterpart of the team's subtractor cells.
- Accepts two WIDTH-bit unsigned operands on a start pulse.
- Adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Used wherever area matters more than latency, as a drop-in arithmetic engine behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- sum  output  WIDTH  registered result A+B mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - sum=0, cout=0, busy=0, done=0.
  - Shift registers, carry flip-flop and bit counter all clear.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads the a/b shift registers, clears the carry flip-flop and counter, and moves to RUN.
  - busy rises on the following cycle.
- RUN:
  - Each edge processes bit i = counter. Inputs are a_sr[0], b_sr[0] and carry.
  - The sum bit shifts into a result shift register from the MSB side. The new carry is registered. Both operand registers shift right by one.
  - The counter increments. After the edge that processes bit WIDTH-1, the state moves to DONE.
  - At that same edge, the full result shift register is copied to sum and the final carry to cout.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - A start sampled in the DONE cycle is accepted as if in IDLE, so back-to-back operations are allowed.
- Latency: start accepted at edge k; sum/cout update and DONE is entered at edge k+WIDTH; done is high during the cycle after edge k+WIDTH.
- busy=1 exactly for the WIDTH cycles of RUN.
- start while busy=1 is ignored. Operands are not re-sampled and the in-flight result is unaffected.
- a and b may change freely after the accepting edge.
- sum/cout hold the last result until the next completion or reset. They never show partial values.
- Counter width is clog2(WIDTH)+1. No wrap-around is possible, since the exit condition is compared against WIDTH-1.
- Reset asserted mid-RUN aborts the operation:
  - Outputs go to their reset values.
  - No done pulse is produced.
  - The previous sum is lost (reads 0).

Decomposition:
- Package add_pkg:
  - state enum (IDLE, RUN, DONE) as a 2-bit typedef;
  - DEFAULT_WIDTH constant;
  - counter-width function.
- Sub-module full_add_cell:
  - combinational; inputs x, y, cin; outputs s, co;
  - built structurally from two half-adder stages and an OR.
  - It is the addition twin of the existing half-subtractor structural cell and is unit-testable alone with an exhaustive 8-row truth table.

Test Plan (WIDTH=8):
1. rst=1 for 2 cycles, then start a=3, b=5 → busy=1 for 8 cycles; done pulse at edge 9 after accept; sum=8, cout=0.
2. start a=255, b=1 → sum=0, cout=1. Then start a=200, b=100 → sum=44, cout=1.
3. start a=0, b=0 → sum=0, cout=0, done after 8 RUN cycles. Also run the exhaustive full_add_cell truth table alongside.
4. start a=10, b=20; pulse start with a=1, b=1 at RUN cycle 3 → ignored; result sum=30, exactly one done pulse.
5. start a=100, b=27; rst=1 at RUN cycle 4 → sum=0, cout=0, busy=0, no done. Next start a=7, b=9 → sum=16.
6. Hold start=1 continuously with a=15, b=17, then a=128, b=128 presented in the DONE cycle → second op accepted in the DONE cycle; sums 32 (cout=0) then 0 (cout=1); done pulses 9 cycles apart.
